// File: rtl/video_output_sequencer_pkg.sv
// Shared video configuration package for the HDMI output side.
// Holds the video configuration record, the output sequencer state
// encoding, its default timeout constants and small counter helpers.
package video_output_sequencer_pkg;

  typedef struct packed {
    logic [3:0] vic_sel;
    logic [1:0] color_space;
    logic       dvi_mode;
    logic       audio_en;
    logic [7:0] h_start_adj;
  } HDMIVideoConfig;

  typedef enum logic [2:0] {
    VS_HOLD       = 3'd0,
    VS_WAIT_LOCK  = 3'd1,
    VS_ARM        = 3'd2,
    VS_WAIT_ACK   = 3'd3,
    VS_WAIT_FRAME = 3'd4,
    VS_RUN        = 3'd5
  } VideoSeqState;

  localparam int DEF_HOLD_CYCLES        = 16;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_ACK_TIMEOUT        = 16;
  localparam int DEF_FRAME_TIMEOUT      = 1 << 22;
  localparam int DEF_NOSIG_TIMEOUT      = 1 << 22;

  // Bits needed to hold 0 .. limit-1; never less than one bit.
  function automatic int cnt_width(input int limit);
    return (limit > 2) ? $clog2(limit) : 1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/video_output_sequencer_sat_counter.sv
// sat_counter: up-counter that stops at LIMIT-1.
// Ports: clock, reset (async, active-low), clear (sync, wins over enable),
//        enable (count one step), done (count has reached LIMIT-1).
module sat_counter
  import video_output_sequencer_pkg::*;
#(
  parameter int LIMIT = 16,
  parameter int WIDTH = cnt_width(LIMIT)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + WIDTH'(1);
    end
  end

  assign done = (count == LAST);

endmodule

// File: rtl/video_output_sequencer.sv
// video_output_sequencer: start/restart sequencing of the RAM-to-video reader.
// Holds the reader in reset while the PLL settles and new configuration is
// applied, fires starttrigger on an input frame start, then confirms the
// acknowledge and first full frame. Retries on PLL loss, config change or
// timeout.
// Ports: clock, reset (async, active-low); pll_locked, frame_start, cfg_in,
//        line_doubler_in, add_line_in, restart, fullcycle (inputs);
//        out_reset_n, starttrigger, cfg_out, line_doubler, add_line, running,
//        no_input, fault_count (registered outputs).
//
// state         | meaning
// VS_HOLD       | reader in reset, configuration loaded every cycle
// VS_WAIT_LOCK  | reader in reset, waiting for a stable PLL lock run
// VS_ARM        | reader released, waiting for an input frame start
// VS_WAIT_ACK   | starttrigger sent, waiting for the reader's restart ack
// VS_WAIT_FRAME | ack seen, waiting for the first full frame
// VS_RUN        | output running
module video_output_sequencer
  import video_output_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES        = DEF_HOLD_CYCLES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int ACK_TIMEOUT        = DEF_ACK_TIMEOUT,
  parameter int FRAME_TIMEOUT      = DEF_FRAME_TIMEOUT,
  parameter int NOSIG_TIMEOUT      = DEF_NOSIG_TIMEOUT
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           pll_locked,
  input  logic           frame_start,
  input  HDMIVideoConfig cfg_in,
  input  logic           line_doubler_in,
  input  logic           add_line_in,
  input  logic           restart,
  input  logic           fullcycle,
  output logic           out_reset_n,
  output logic           starttrigger,
  output HDMIVideoConfig cfg_out,
  output logic           line_doubler,
  output logic           add_line,
  output logic           running,
  output logic           no_input,
  output logic [7:0]     fault_count
);

  VideoSeqState state;

  logic hold_done, lock_done, ack_done, frame_done, nosig_done;
  logic pll_lost, cfg_mismatch;

  // Loss of lock only counts once the reader has been released; in
  // WAIT_LOCK the lock counter clear already handles it.
  assign pll_lost = !pll_locked &&
                    (state inside {VS_ARM, VS_WAIT_ACK, VS_WAIT_FRAME, VS_RUN});

  assign cfg_mismatch = (cfg_in != cfg_out) ||
                        (line_doubler_in != line_doubler) ||
                        (add_line_in != add_line);

  // Each timer is held at zero outside its own state, so it always starts
  // from zero on state entry.
  sat_counter #(.LIMIT(HOLD_CYCLES)) u_hold_cnt (
    .clock(clock), .reset(reset),
    .clear(state != VS_HOLD), .enable(state == VS_HOLD), .done(hold_done)
  );

  sat_counter #(.LIMIT(LOCK_STABLE_CYCLES)) u_lock_cnt (
    .clock(clock), .reset(reset),
    .clear((state != VS_WAIT_LOCK) || !pll_locked), .enable(state == VS_WAIT_LOCK),
    .done(lock_done)
  );

  sat_counter #(.LIMIT(ACK_TIMEOUT)) u_ack_cnt (
    .clock(clock), .reset(reset),
    .clear(state != VS_WAIT_ACK), .enable(state == VS_WAIT_ACK), .done(ack_done)
  );

  sat_counter #(.LIMIT(FRAME_TIMEOUT)) u_frame_cnt (
    .clock(clock), .reset(reset),
    .clear(state != VS_WAIT_FRAME), .enable(state == VS_WAIT_FRAME), .done(frame_done)
  );

  sat_counter #(.LIMIT(NOSIG_TIMEOUT)) u_nosig_cnt (
    .clock(clock), .reset(reset),
    .clear(state != VS_ARM), .enable(state == VS_ARM), .done(nosig_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= VS_HOLD;
      out_reset_n  <= 1'b0;
      starttrigger <= 1'b0;
      running      <= 1'b0;
      no_input     <= 1'b0;
      fault_count  <= 8'd0;
      cfg_out      <= '0;
      line_doubler <= 1'b0;
      add_line     <= 1'b0;
    end else begin
      starttrigger <= 1'b0;
      if (pll_lost) begin
        state       <= VS_HOLD;
        out_reset_n <= 1'b0;
        running     <= 1'b0;
        fault_count <= sat_inc8(fault_count);
      end else if ((state != VS_HOLD) && cfg_mismatch) begin
        state       <= VS_HOLD;
        out_reset_n <= 1'b0;
        running     <= 1'b0;
      end else begin
        unique case (state)
          VS_HOLD: begin
            cfg_out      <= cfg_in;
            line_doubler <= line_doubler_in;
            add_line     <= add_line_in;
            if (hold_done) state <= VS_WAIT_LOCK;
          end
          VS_WAIT_LOCK: begin
            if (lock_done && pll_locked) begin
              state       <= VS_ARM;
              out_reset_n <= 1'b1;
            end
          end
          VS_ARM: begin
            if (frame_start) begin
              starttrigger <= 1'b1;
              no_input     <= 1'b0;
              state        <= VS_WAIT_ACK;
            end else if (nosig_done) begin
              no_input <= 1'b1;
            end
          end
          VS_WAIT_ACK: begin
            if (restart) begin
              state <= VS_WAIT_FRAME;
            end else if (ack_done) begin
              state       <= VS_HOLD;
              out_reset_n <= 1'b0;
              fault_count <= sat_inc8(fault_count);
            end
          end
          VS_WAIT_FRAME: begin
            if (fullcycle) begin
              state   <= VS_RUN;
              running <= 1'b1;
            end else if (frame_done) begin
              state       <= VS_HOLD;
              out_reset_n <= 1'b0;
              fault_count <= sat_inc8(fault_count);
            end
          end
          VS_RUN: begin
          end
          default: begin
            state       <= VS_HOLD;
            out_reset_n <= 1'b0;
            running     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/video_output_sequencer.md
# video_output_sequencer

Controls startup and restart of the HDMI-side output pipeline. It holds the RAM-to-video reader in reset while the output PLL settles and while new video configuration is applied, then fires its start trigger on a captured input frame start. It confirms the handshake and first full frame, and retries on PLL loss, configuration change or timeout. It sits between the capture side, the config/OSD controller and the RAM-to-video reader, all on the output pixel clock.

## Interface
Parameters:
- HOLD_CYCLES, 16: cycles `out_reset_n` is held low on every (re)start.
- LOCK_STABLE_CYCLES, 1024: consecutive `pll_locked` cycles required before arming.
- ACK_TIMEOUT, 16: maximum cycles from `starttrigger` to `restart` acknowledge.
- FRAME_TIMEOUT, 2^22: maximum cycles from acknowledge to `fullcycle`.
- NOSIG_TIMEOUT, 2^22: cycles in ARM without `frame_start` before `no_input` is raised.

Ports:
- clock  in  1  output pixel clock.
- reset  in  1  asynchronous, active-low.
- pll_locked  in  1  output PLL lock, already synchronous to `clock`.
- frame_start  in  1  one-cycle pulse at input frame start, synchronous.
- cfg_in  in  HDMIVideoConfig  requested video configuration.
- line_doubler_in, add_line_in  in  1 each  requested mode bits.
- restart  in  1  reader's start acknowledge pulse.
- fullcycle  in  1  reader's first-full-frame level.
- out_reset_n  out  1  active-low reset to the reader.
- starttrigger  out  1  one-cycle start pulse to the reader.
- cfg_out  out  HDMIVideoConfig  applied configuration.
- line_doubler, add_line  out  1 each  applied mode bits.
- running  out  1  high in RUN.
- no_input  out  1  ARM has waited longer than NOSIG_TIMEOUT.
- fault_count  out  8  count of timeouts and PLL losses; saturates at 255.

## Operation
- States: HOLD → WAIT_LOCK → ARM → WAIT_ACK → WAIT_FRAME → RUN.
- HOLD:
  - `out_reset_n`=0.
  - `cfg_out`, `line_doubler` and `add_line` load from their inputs every cycle.
  - Leaves for WAIT_LOCK after HOLD_CYCLES cycles.
- WAIT_LOCK:
  - `out_reset_n`=0.
  - The lock counter increments while `pll_locked`=1 and clears when it is 0.
  - Reaching LOCK_STABLE_CYCLES → ARM.
- ARM:
  - `out_reset_n`=1.
  - On `frame_start`: pulse `starttrigger` for exactly one cycle → WAIT_ACK.
  - The nosig counter saturates at NOSIG_TIMEOUT and sets `no_input`. `frame_start` clears `no_input`.
- WAIT_ACK:
  - `restart` → WAIT_FRAME.
  - ACK_TIMEOUT expiry → fault_count+1 → HOLD.
- WAIT_FRAME:
  - `fullcycle`=1 → RUN.
  - FRAME_TIMEOUT expiry → fault_count+1 → HOLD.
- RUN: `running`=1. Leaves only via the global exits below.
- Global exits, evaluated in every state except HOLD, in priority order:
  1. `pll_locked`=0 → HOLD with fault_count+1. Applies from ARM onward only; in WAIT_LOCK the counter clear covers it.
  2. Config mismatch → HOLD with no fault increment. Mismatch means `cfg_in`≠`cfg_out`, `line_doubler_in`≠`line_doubler`, or `add_line_in`≠`add_line`.
- Simultaneous `frame_start` and a global exit: the exit wins and `starttrigger` stays 0.
- A mismatch arising in HOLD restarts nothing; the new value is simply loaded.
- `fault_count` never wraps.
- Configuration outputs never change while `out_reset_n`=1.

## Timing
- Every output is a register; there is no combinational input-to-output path.
- Reset values:
  - state=HOLD, `out_reset_n`=0, `starttrigger`=0, `running`=0, `no_input`=0, `fault_count`=0.
  - `cfg_out`=all-zero, `line_doubler`=0, `add_line`=0. These load from their inputs on the first HOLD cycle.
  - All counters =0.
- `out_reset_n` rises on the first ARM cycle. It falls on the cycle after a global exit is detected.
- `starttrigger` is high on the cycle after the `frame_start` sample.
- Timeout counters restart at 0 on every state entry. Timeouts are evaluated as counter == limit−1, so a state lasts exactly the limit in cycles.
- `running` deasserts in the same cycle as the RUN→HOLD transition register update.
- Reset asserted mid-operation forces the reset values asynchronously. Release resumes in HOLD.

## Structure
- HDMIVideoConfig stays in the shared config package.
- Add a state enum `VideoSeqState` and default timeout constants to that package.
- One sub-module, `sat_counter` (parameterised width and limit, with clear, enable and done outputs). Instantiate it for the hold, lock, ack/frame and nosig counters.

## Test plan
- Normal start:
  - Stimulus: `pll_locked`=1 from reset, HOLD_CYCLES=16, LOCK_STABLE_CYCLES=1024; `frame_start` at cycle 2000, `restart` one cycle after `starttrigger`, `fullcycle` 100 cycles later.
  - Response: `out_reset_n` rises at cycle 1040; one `starttrigger` pulse at cycle 2001; `running`=1; `fault_count`=0.
- Lock glitch:
  - Stimulus: `pll_locked` drops for 1 cycle at lock count 500.
  - Response: count restarts; ARM is entered 1024 cycles after relock.
- Ack timeout:
  - Stimulus: `restart` never asserted.
  - Response: HOLD exactly 16 cycles after `starttrigger`; `fault_count`=1; retry follows.
- Config change in RUN:
  - Stimulus: `add_line_in` toggles.
  - Response: `out_reset_n`=0 next cycle; `add_line` updates during HOLD only; `fault_count` unchanged.
- No input:
  - Stimulus: no `frame_start` for NOSIG_TIMEOUT (set to 64).
  - Response: `no_input`=1; a later `frame_start` clears it and fires `starttrigger`.
- Saturation:
  - Stimulus: 300 forced ack timeouts.
  - Response: `fault_count`=255.
